game_datapath: RTL and testbench

- Responder/datapath side of the game control FSM: executes one object phase (wall or bird) per `start` request.
- Each phase erases the object from the VGA frame buffer, updates its physics, redraws it, checks collision, then returns a one-cycle `flag` (phase done).
- Drives the VGA adapter plot interface, one pixel per cycle.
- Produces the `collision` level that the control FSM consumes.

---
 rtl/game_datapath.sv | 262 ++++++++++++++++++++++++++
 tb/tb_game_datapath.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_datapath.sv
// game_datapath -- object-phase engine behind the game control FSM.
//
// Each accepted `start` runs one phase on the object chosen by `sel`
// (0 = wall, 1 = bird). A phase has five steps:
//   1. Erase the object's rectangle in the frame buffer.
//   2. Advance its physics for one step.
//   3. Redraw the rectangle.
//   4. Test for a collision.
//   5. Pulse `flag` for one cycle.
// Pixels go out one per cycle on the VGA adapter plot interface.
//
// Ports:
//   clk, resetn      clock; synchronous active-low reset
//   start, sel       phase request and object select (sampled together)
//   flap             player key, any pulse width; stays pending until a
//                    bird update consumes it
//   busy             high from the cycle after acceptance through DONE
//   flag             one-cycle phase-done pulse
//   collision        sticky collision level (cleared only by reset)
//   x, y, colour     pixel coordinate and colour, valid while plot = 1
//   plot             pixel write strobe
//   score            walls passed, saturating at 255
//
// Build option: WALL_ACCEL_EN
//   When defined, the wall moves 1 + score[4:3] pixels per phase.
//   Otherwise it moves 1 pixel per phase.
module game_datapath #(
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          BIRD_X      = 40,
    parameter int          BIRD_SIZE   = 4,
    parameter int          WALL_W      = 8,
    parameter int          GAP_H       = 32,
    parameter int          GRAVITY     = 1,
    parameter int          FLAP_V      = 4,
    parameter int          MAX_FALL    = 4,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  BIRD_COLOUR = 3'b110,
    parameter logic [2:0]  WALL_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       sel,
    input  logic       flap,
    output logic       busy,
    output logic       flag,
    output logic       collision,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [7:0] score
);

    localparam int BIRD_MAX  = SCREEN_H - BIRD_SIZE;     // lowest legal bird_y
    localparam int GAP_RANGE = SCREEN_H - GAP_H;         // gap_y spans 0..GAP_RANGE-1
    localparam int BIRD_Y0   = (SCREEN_H - BIRD_SIZE) / 2;
    localparam int GAP_Y0    = (SCREEN_H - GAP_H) / 2;
    localparam int WALL_X0   = SCREEN_W - WALL_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_UPDATE, S_DRAW, S_CHECK, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [7:0]        col_q, col_d;
    logic [6:0]        row_q, row_d;
    logic [6:0]        bird_y_q, bird_y_d;
    logic signed [4:0] vel_q, vel_d;
    logic [7:0]        wall_x_q, wall_x_d;
    logic [6:0]        gap_y_q, gap_y_d;
    logic [7:0]        score_q, score_d;
    logic              flap_pend_q, flap_pend_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              collision_q, collision_d;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic [2:0]        colour_q, colour_d;
    logic              plot_q, plot_d;

    logic [7:0]        obj_w_m1;
    logic [6:0]        obj_h_m1;
    logic              last_px;
    logic signed [5:0] vel_sum;
    logic signed [4:0] vel_new;
    logic signed [8:0] y_sum;
    logic [7:0]        speed;
    logic [6:0]        gap_r, gap_new;
    logic              bird_edge, h_overlap, out_gap;
    logic [7:0]        base_x;
    logic [6:0]        base_y;
    logic              in_gap;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        col_d       = col_q;
        row_d       = row_q;
        bird_y_d    = bird_y_q;
        vel_d       = vel_q;
        wall_x_d    = wall_x_q;
        gap_y_d     = gap_y_q;
        score_d     = score_q;
        collision_d = collision_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        plot_d      = 1'b0;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // A flap arriving in the consume cycle survives because the
        // consume branch below re-ORs the live input.
        flap_pend_d = flap_pend_q | flap;

        obj_w_m1 = sel_q ? 8'(BIRD_SIZE - 1) : 8'(WALL_W - 1);
        obj_h_m1 = sel_q ? 7'(BIRD_SIZE - 1) : 7'(SCREEN_H - 1);
        last_px  = (col_q == obj_w_m1) && (row_q == obj_h_m1);

        // Bird physics: velocity first, then position clamped to the screen.
        vel_sum = $signed({vel_q[4], vel_q}) + $signed(6'(GRAVITY));
        if (flap_pend_q)
            vel_new = 5'(-FLAP_V);
        else if (vel_sum > $signed(6'(MAX_FALL)))
            vel_new = 5'(MAX_FALL);
        else
            vel_new = vel_sum[4:0];
        y_sum = $signed({2'b00, bird_y_q}) + $signed({{4{vel_new[4]}}, vel_new});

`ifdef WALL_ACCEL_EN
        speed = 8'd1 + {6'd0, score_q[4:3]};
`else
        speed = 8'd1;
`endif
        // Fold the 7-bit LFSR slice into the legal gap range.
        gap_r   = lfsr_q[6:0];
        gap_new = (gap_r >= 7'(GAP_RANGE)) ? gap_r - 7'(GAP_RANGE) : gap_r;

        bird_edge = (bird_y_q == 7'd0) || (bird_y_q == 7'(BIRD_MAX));
        h_overlap = ({1'b0, wall_x_q} < 9'(BIRD_X + BIRD_SIZE)) &&
                    (({1'b0, wall_x_q} + 9'(WALL_W)) > 9'(BIRD_X));
        out_gap   = (bird_y_q < gap_y_q) ||
                    (({1'b0, bird_y_q} + 8'(BIRD_SIZE)) > ({1'b0, gap_y_q} + 8'(GAP_H)));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ERASE;
                    sel_d   = sel;
                    col_d   = 8'd0;
                    row_d   = 7'd0;
                end
            end
            S_ERASE, S_DRAW: begin
                if (last_px) begin
                    state_d = (state_q == S_ERASE) ? S_UPDATE : S_CHECK;
                end else if (col_q == obj_w_m1) begin
                    col_d = 8'd0;
                    row_d = row_q + 7'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            S_UPDATE: begin
                state_d = S_DRAW;
                col_d   = 8'd0;
                row_d   = 7'd0;
                // After a collision the scene freezes; only the scans continue.
                if (!collision_q) begin
                    if (sel_q) begin
                        vel_d = vel_new;
                        if (flap_pend_q)
                            flap_pend_d = flap;
                        if (y_sum[8])
                            bird_y_d = 7'd0;
                        else if (y_sum > $signed(9'(BIRD_MAX)))
                            bird_y_d = 7'(BIRD_MAX);
                        else
                            bird_y_d = y_sum[6:0];
                    end else if (wall_x_q < speed) begin
                        wall_x_d = 8'(WALL_X0);
                        gap_y_d  = gap_new;
                        score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else begin
                        wall_x_d = wall_x_q - speed;
                    end
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                if (bird_edge || (h_overlap && out_gap))
                    collision_d = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pixel outputs are computed from the next-cycle scan position, so
        // they are registered in step with the state they belong to. Using
        // the _d geometry lets DRAW see the position just written by UPDATE.
        base_x = sel_d ? 8'(BIRD_X) : wall_x_d;
        base_y = sel_d ? bird_y_d : 7'd0;
        in_gap = !sel_d && (row_d >= gap_y_d) &&
                 ({1'b0, row_d} < ({1'b0, gap_y_d} + 8'(GAP_H)));
        if (state_d == S_ERASE || state_d == S_DRAW) begin
            x_d      = base_x + col_d;
            y_d      = base_y + row_d;
            colour_d = (state_d == S_ERASE) ? BG_COLOUR :
                       (sel_d ? BIRD_COLOUR : WALL_COLOUR);
            // Gap rows still take their scan cycle but write nothing.
            plot_d   = !in_gap;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            col_q       <= 8'd0;
            row_q       <= 7'd0;
            bird_y_q    <= 7'(BIRD_Y0);
            vel_q       <= 5'sd0;
            wall_x_q    <= 8'(WALL_X0);
            gap_y_q     <= 7'(GAP_Y0);
            score_q     <= 8'd0;
            flap_pend_q <= 1'b0;
            lfsr_q      <= 8'hA5;
            collision_q <= 1'b0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colour_q    <= 3'd0;
            plot_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            wall_x_q    <= wall_x_d;
            gap_y_q     <= gap_y_d;
            score_q     <= score_d;
            flap_pend_q <= flap_pend_d;
            lfsr_q      <= lfsr_d;
            collision_q <= collision_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign flag      = (state_q == S_DONE);
    assign collision = collision_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign score     = score_q;

endmodule

// File: tb/tb_game_datapath.sv
// Directed bench for game_datapath.
// dut1 uses the default geometry. dut2 narrows the screen to 16 pixels, so
// the wall wraps after 9 phases instead of 153; every other parameter,
// including the gap range, matches dut1.
module tb_game_datapath;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start1, sel1, start2, sel2, flap;
    logic       busy1, flag1, coll1, plot1;
    logic [7:0] x1, score1;
    logic [6:0] y1;
    logic [2:0] col1;
    logic       busy2, flag2, coll2, plot2;
    logic [7:0] x2, score2;
    logic [6:0] y2;
    logic [2:0] col2;

    always #5 clk = ~clk;

    game_datapath dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .sel(sel1), .flap(flap),
        .busy(busy1), .flag(flag1), .collision(coll1), .x(x1), .y(y1),
        .colour(col1), .plot(plot1), .score(score1)
    );

    game_datapath #(.SCREEN_W(16)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .sel(sel2), .flap(1'b0),
        .busy(busy2), .flag(flag2), .collision(coll2), .x(x2), .y(y2),
        .colour(col2), .plot(plot2), .score(score2)
    );

    // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seeded A5 by reset.
    logic [7:0] lfsr_m;
    always @(posedge clk) begin
        if (!resetn) lfsr_m <= 8'hA5;
        else         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    int nerr = 0;
    int nchk = 0;

    int r_eplots, r_dplots, r_bad, r_flag_cyc, r_nflag, r_timeout;
    int r_ex0, r_ey0, r_dx0, r_dy0, r_gap_lo, r_gap_n;
    logic [7:0] r_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Runs one phase on dut d (0/1) with object s, called at a negedge.
    // Optionally re-pulses start in cycle 5 and in the flag cycle.
    task automatic run_phase(input int d, input logic s, input logic stray);
        int n;
        logic done;
        logic p, f, b;
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc, dcol;
        logic rows [0:127];
        n    = s ? 16 : 960;
        dcol = s ? 3'b110 : 3'b010;
        r_eplots = 0; r_dplots = 0; r_bad = 0; r_flag_cyc = -1; r_nflag = 0;
        r_timeout = 0; r_ex0 = -1; r_ey0 = -1; r_dx0 = -1; r_dy0 = -1;
        r_gap_lo = -1; r_gap_n = 0; r_lfsr = 8'h00;
        for (int i = 0; i < 128; i++) rows[i] = 1'b0;
        if (d == 0) begin start1 = 1'b1; sel1 = s; end
        else        begin start2 = 1'b1; sel2 = s; end
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 2 * n + 10 && !done; k++) begin
            if (d == 0) begin p = plot1; f = flag1; b = busy1; xx = x1; yy = y1; cc = col1; end
            else        begin p = plot2; f = flag2; b = busy2; xx = x2; yy = y2; cc = col2; end
            if (p && cc == 3'b000) begin
                if (r_eplots == 0) begin r_ex0 = int'(xx); r_ey0 = int'(yy); end
                r_eplots++;
            end else if (p && cc == dcol) begin
                if (r_dplots == 0) begin r_dx0 = int'(xx); r_dy0 = int'(yy); end
                r_dplots++;
                rows[yy] = 1'b1;
            end else if (p) begin
                r_bad++;
            end
            if (k == n + 1) r_lfsr = lfsr_m;
            if (f) begin r_nflag++; r_flag_cyc = k; end
            if (r_nflag > 0 && !f && !b) done = 1'b1;
            if (stray && (k == 5 || f)) begin
                if (d == 0) start1 = 1'b1; else start2 = 1'b1;
            end else begin
                start1 = 1'b0; start2 = 1'b0;
            end
            @(negedge clk);
        end
        start1 = 1'b0; start2 = 1'b0;
        if (!done) r_timeout = 1;
        repeat (4) begin
            if ((d == 0 && flag1) || (d == 1 && flag2)) r_nflag++;
            @(negedge clk);
        end
        if (!s) begin
            for (int i = 0; i < 120; i++)
                if (!rows[i]) begin
                    if (r_gap_lo < 0) r_gap_lo = i;
                    r_gap_n++;
                end
        end
    endtask

    initial begin
        int exp_y [0:17];
        int exp_gap;
        int nf;
        exp_y = '{59, 61, 64, 68, 72, 76, 80, 84, 88, 92, 96, 100, 104, 108, 112, 116, 116, 116};
        resetn = 1'b0; start1 = 1'b0; sel1 = 1'b0; start2 = 1'b0; sel2 = 1'b0; flap = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy1, 0);
        chk("rst_flag", flag1, 0);
        chk("rst_plot", plot1, 0);
        chk("rst_coll", coll1, 0);
        chk("rst_x", x1, 0);
        chk("rst_y", y1, 0);
        chk("rst_colour", col1, 0);
        chk("rst_score", score1, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Bird phase, no flap
        run_phase(0, 1'b1, 1'b0);
        chk("bird_timeout", r_timeout, 0);
        chk("bird_eplots", r_eplots, 16);
        chk("bird_dplots", r_dplots, 16);
        chk("bird_bad", r_bad, 0);
        chk("bird_ex0", r_ex0, 40);
        chk("bird_ey0", r_ey0, 58);
        chk("bird_dx0", r_dx0, 40);
        chk("bird_dy0", r_dy0, 59);
        chk("bird_flagcyc", r_flag_cyc, 35);
        chk("bird_nflag", r_nflag, 1);
        chk("bird_coll", coll1, 0);

        // Flap consumed once, then gravity resumes from -4
        do_reset();
        flap = 1'b1; @(negedge clk); flap = 1'b0;
        run_phase(0, 1'b1, 1'b0);
        chk("flap_dy0", r_dy0, 54);
        run_phase(0, 1'b1, 1'b0);
        chk("flap2_ey0", r_ey0, 54);
        chk("flap2_dy0", r_dy0, 51);

        // Wall phase
        do_reset();
        run_phase(0, 1'b0, 1'b0);
        chk("wall_timeout", r_timeout, 0);
        chk("wall_eplots", r_eplots, 704);
        chk("wall_dplots", r_dplots, 704);
        chk("wall_bad", r_bad, 0);
        chk("wall_ex0", r_ex0, 152);
        chk("wall_dx0", r_dx0, 151);
        chk("wall_gap_lo", r_gap_lo, 44);
        chk("wall_gap_n", r_gap_n, 32);
        chk("wall_flagcyc", r_flag_cyc, 1923);
        chk("wall_score", score1, 0);

        // Bird falls to the floor and freezes there
        do_reset();
        for (int p = 0; p < 18; p++) begin
            run_phase(0, 1'b1, 1'b0);
            chk($sformatf("fall%0d_dy0", p + 1), r_dy0, exp_y[p]);
            if (p == 14) chk("fall15_coll", coll1, 0);
            if (p == 15) chk("fall16_coll", coll1, 1);
            if (p == 17) begin
                chk("fall18_ey0", r_ey0, 116);
                chk("fall18_nflag", r_nflag, 1);
                chk("fall18_flagcyc", r_flag_cyc, 35);
                chk("fall18_coll", coll1, 1);
            end
        end

        // Wall wrap on the narrow instance, with stray starts during phase 9
        do_reset();
        for (int p = 1; p <= 9; p++) begin
            run_phase(1, 1'b0, p == 9);
            if (p == 1) begin
                chk("wrap1_ex0", r_ex0, 8);
                chk("wrap1_dx0", r_dx0, 7);
            end
            if (p == 8) begin
                chk("wrap8_dx0", r_dx0, 0);
                chk("wrap8_score", score2, 0);
            end
        end
        exp_gap = int'(r_lfsr[6:0]);
        if (exp_gap >= 88) exp_gap = exp_gap - 88;
        chk("wrap9_ex0", r_ex0, 0);
        chk("wrap9_dx0", r_dx0, 8);
        chk("wrap9_score", score2, 1);
        chk("wrap9_gap_lo", r_gap_lo, exp_gap);
        chk("wrap9_gap_n", r_gap_n, 32);
        chk("wrap9_nflag", r_nflag, 1);
        chk("wrap9_flagcyc", r_flag_cyc, 1923);
        chk("wrap9_timeout", r_timeout, 0);

        // Reset in the middle of a wall DRAW
        do_reset();
        start1 = 1'b1; sel1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (1000) @(negedge clk);
        chk("mid_plot_pre", plot1, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_plot", plot1, 0);
        chk("mid_busy", busy1, 0);
        chk("mid_flag", flag1, 0);
        chk("mid_x", x1, 0);
        resetn = 1'b1;
        nf = 0;
        repeat (2000) begin
            if (flag1) nf++;
            @(negedge clk);
        end
        chk("mid_noflag", nf, 0);
        run_phase(0, 1'b0, 1'b0);
        chk("mid_ex0", r_ex0, 152);
        chk("mid_dx0", r_dx0, 151);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
